// File: rtl/axi4_mem_responder.sv
// AXI4 slave backed by a dual-port block RAM. It has independent read and write
// engines, each with one outstanding INCR/FIXED burst of up to 256 beats.
module axi4_mem_responder #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_MEM_AW           = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << C_MEM_AW;
  localparam logic [C_MEM_AW-1:0] IDX_ONE = {{(C_MEM_AW-1){1'b0}}, 1'b1};
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_e;

  logic [C_S_AXI_DATA_WIDTH-1:0] ram [DEPTH];
  logic [C_S_AXI_DATA_WIDTH-1:0] ramRdata_q;
  logic                          ramRdEn;
  logic [C_MEM_AW-1:0]           ramRdIdx;
  logic                          ramWe;

  wstate_e             wState_q, wState_d;
  logic [C_MEM_AW-1:0] wIdx_q, wIdx_d;
  logic [7:0]          wLen_q, wLen_d, wBeat_q, wBeat_d;
  logic                wIncr_q, wIncr_d, wErr_q, wErr_d, wProt_q, wProt_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;

  rstate_e                       rState_q, rState_d;
  logic [C_MEM_AW-1:0]           rIdx_q, rIdx_d;
  logic [7:0]                    rLen_q, rLen_d, rBeat_q, rBeat_d;
  logic                          rIncr_q, rIncr_d, rErr_q, rErr_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                    rresp_q, rresp_d;
  logic                          rlast_q, rlast_d, arready_q, arready_d, rvalid_q, rvalid_d;

  logic awHs, wHs, bHs, arHs, rHs, wLastBeat;
  logic unusedAddrBits;

  assign unusedAddrBits = ^{S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:C_MEM_AW+3], S_AXI_AWADDR[2:0],
                            S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:C_MEM_AW+3], S_AXI_ARADDR[2:0]};

  assign awHs      = S_AXI_AWVALID && awready_q;
  assign wHs       = S_AXI_WVALID && wready_q;
  assign bHs       = bvalid_q && S_AXI_BREADY;
  assign arHs      = S_AXI_ARVALID && arready_q;
  assign rHs       = rvalid_q && S_AXI_RREADY;
  assign wLastBeat = (wBeat_q == wLen_q);

  always_comb begin
    wState_d = wState_q;
    wIdx_d   = wIdx_q;
    wLen_d   = wLen_q;
    wBeat_d  = wBeat_q;
    wIncr_d  = wIncr_q;
    wErr_d   = wErr_q;
    wProt_d  = wProt_q;
    bresp_d  = bresp_q;
    case (wState_q)
      W_IDLE: begin
        if (awHs) begin
          wIdx_d   = S_AXI_AWADDR[C_MEM_AW+2:3];
          wLen_d   = S_AXI_AWLEN;
          wBeat_d  = 8'd0;
          wIncr_d  = (S_AXI_AWBURST == 2'b01);
          wErr_d   = (S_AXI_AWSIZE != 3'b011) || S_AXI_AWBURST[1];
          wProt_d  = 1'b0;
          wState_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wHs) begin
          wBeat_d = wBeat_q + 8'd1;
          if (wIncr_q) wIdx_d = wIdx_q + IDX_ONE;
          if (S_AXI_WLAST != wLastBeat) wProt_d = 1'b1;
          // The beat count, not WLAST, decides where the burst ends.
          if (wLastBeat) begin
            bresp_d  = (wErr_q || wProt_q || (S_AXI_WLAST != wLastBeat)) ? RESP_SLVERR : RESP_OKAY;
            wState_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bHs) wState_d = W_IDLE;
      end
      default: wState_d = W_IDLE;
    endcase
    awready_d = (wState_d == W_IDLE);
    wready_d  = (wState_d == W_DATA);
    bvalid_d  = (wState_d == W_RESP);
  end

  assign ramWe = wHs && !wErr_q && !rst;

  always_comb begin
    rState_d = rState_q;
    rIdx_d   = rIdx_q;
    rLen_d   = rLen_q;
    rBeat_d  = rBeat_q;
    rIncr_d  = rIncr_q;
    rErr_d   = rErr_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    ramRdEn  = 1'b0;
    ramRdIdx = rIdx_q;
    case (rState_q)
      R_IDLE: begin
        if (arHs) begin
          rIdx_d   = S_AXI_ARADDR[C_MEM_AW+2:3];
          rLen_d   = S_AXI_ARLEN;
          rBeat_d  = 8'd0;
          rIncr_d  = (S_AXI_ARBURST == 2'b01);
          rErr_d   = (S_AXI_ARSIZE != 3'b011) || S_AXI_ARBURST[1];
          ramRdEn  = 1'b1;
          ramRdIdx = S_AXI_ARADDR[C_MEM_AW+2:3];
          rState_d = R_FETCH;
        end
      end
      R_FETCH: begin
        rdata_d  = rErr_q ? '0 : ramRdata_q;
        rresp_d  = rErr_q ? RESP_SLVERR : RESP_OKAY;
        rlast_d  = (rBeat_q == rLen_q);
        rState_d = R_DATA;
      end
      R_DATA: begin
        if (rHs) begin
          if (rlast_q) begin
            rlast_d  = 1'b0;
            rState_d = R_IDLE;
          end else begin
            rIdx_d   = rIncr_q ? rIdx_q + IDX_ONE : rIdx_q;
            rBeat_d  = rBeat_q + 8'd1;
            ramRdEn  = 1'b1;
            ramRdIdx = rIncr_q ? rIdx_q + IDX_ONE : rIdx_q;
            rState_d = R_FETCH;
          end
        end
      end
      default: rState_d = R_IDLE;
    endcase
    arready_d = (rState_d == R_IDLE);
    rvalid_d  = (rState_d == R_DATA);
  end

  // Both RAM ports sample the array at the same edge, so a same-word collision reads the old data.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_AXI_WSTRB[b]) ram[wIdx_q][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ramRdEn) ramRdata_q <= ram[ramRdIdx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wState_q  <= W_IDLE;
      wIdx_q    <= '0;
      wLen_q    <= '0;
      wBeat_q   <= '0;
      wIncr_q   <= 1'b0;
      wErr_q    <= 1'b0;
      wProt_q   <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rState_q  <= R_IDLE;
      rIdx_q    <= '0;
      rLen_q    <= '0;
      rBeat_q   <= '0;
      rIncr_q   <= 1'b0;
      rErr_q    <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      wState_q  <= wState_d;
      wIdx_q    <= wIdx_d;
      wLen_q    <= wLen_d;
      wBeat_q   <= wBeat_d;
      wIncr_q   <= wIncr_d;
      wErr_q    <= wErr_d;
      wProt_q   <= wProt_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      rState_q  <= rState_d;
      rIdx_q    <= rIdx_d;
      rLen_q    <= rLen_d;
      rBeat_q   <= rBeat_d;
      rIncr_q   <= rIncr_d;
      rErr_q    <= rErr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RVALID  = rvalid_q;

endmodule
